// File: rtl/exception_reporter_pkg.sv
// Shared types for the exception reporter: CPU configuration, exception causes,
// instruction IDs, reporter states and the modular ID age helper.
package exception_reporter_pkg;

  localparam int LOG2_MAX_IDS = 6;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;

  typedef struct packed {
    logic INCLUDE_M_MODE;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{INCLUDE_M_MODE: 1'b1};

  typedef enum logic [4:0] {
    INST_ADDR_MISALIGNED       = 5'd0,
    INST_ACCESS_FAULT          = 5'd1,
    ILLEGAL_INST               = 5'd2,
    BREAKPOINT                 = 5'd3,
    LOAD_ADDR_MISALIGNED       = 5'd4,
    LOAD_FAULT                 = 5'd5,
    STORE_AMO_ADDR_MISALIGNED  = 5'd6,
    STORE_AMO_FAULT            = 5'd7,
    ECALL_U                    = 5'd8,
    ECALL_S                    = 5'd9,
    ECALL_M                    = 5'd11,
    INST_PAGE_FAULT            = 5'd12,
    LOAD_PAGE_FAULT            = 5'd13,
    STORE_OR_AMO_PAGE_FAULT    = 5'd15
  } exception_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    DISCARD
  } reporter_state_t;

  // Distance from the next retiring ID; wraps naturally in LOG2_MAX_IDS bits.
  function automatic id_t id_age(input id_t id, input id_t oldest);
    return id - oldest;
  endfunction

endpackage

// File: rtl/exception_reporter_if.sv
// Exception link between one execution unit's reporter and the global controller.
interface exception_interface;
  import exception_reporter_pkg::*;

  logic            valid;
  exception_code_t code;
  id_t             id;
  logic [31:0]     tval;
  logic            ack;

  modport unit (
    output valid,
    output code,
    output id,
    output tval,
    input  ack
  );

  modport controller (
    input  valid,
    input  code,
    input  id,
    input  tval,
    output ack
  );

endinterface

// File: rtl/exception_reporter.sv
// Holds the oldest exception raised by one unit, presents it until acknowledged,
// then swallows reports until the controller's post-exception suppress window ends.
module exception_reporter
  import exception_reporter_pkg::*;
#(
  parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 report_valid,
  input  exception_code_t      report_code,
  input  id_t                  report_id,
  input  logic [31:0]          report_tval,
  input  id_t                  oldest_id,
  input  logic                 writeback_suppress,
  input  logic                 init_clear,
  exception_interface.unit     exception,
  output logic                 report_dropped,
  output logic                 discarding
);

  localparam logic MModeEn = CONFIG.INCLUDE_M_MODE;

  reporter_state_t state_q, state_d;
  logic            seen_suppress_q, seen_suppress_d;
  exception_code_t code_q;
  id_t             id_q;
  logic [31:0]     tval_q;

  logic capture;
  logic drop;
  id_t  newAge;
  id_t  pendAge;

  // Ack beats a simultaneous report, and equal ages keep the entry already held.
  always_comb begin
    state_d         = state_q;
    seen_suppress_d = seen_suppress_q;
    capture         = 1'b0;
    drop            = 1'b0;
    newAge          = id_age(report_id, oldest_id);
    pendAge         = id_age(id_q, oldest_id);

    if (init_clear) begin
      state_d         = IDLE;
      seen_suppress_d = 1'b0;
      drop            = report_valid;
    end else begin
      case (state_q)
        IDLE: begin
          if (report_valid) begin
            capture = 1'b1;
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (exception.ack) begin
            state_d         = DISCARD;
            seen_suppress_d = 1'b0;
            drop            = report_valid;
          end else if (report_valid) begin
            if (newAge < pendAge) capture = 1'b1;
            else drop = 1'b1;
          end
        end
        DISCARD: begin
          drop = report_valid;
          if (writeback_suppress) begin
            seen_suppress_d = 1'b1;
          end else if (seen_suppress_q) begin
            state_d         = IDLE;
            seen_suppress_d = 1'b0;
          end
        end
        default: begin
          state_d         = IDLE;
          seen_suppress_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      seen_suppress_q <= 1'b0;
      code_q          <= INST_ADDR_MISALIGNED;
      id_q            <= '0;
      tval_q          <= '0;
    end else begin
      state_q         <= state_d;
      seen_suppress_q <= seen_suppress_d;
      if (init_clear) begin
        code_q <= INST_ADDR_MISALIGNED;
        id_q   <= '0;
        tval_q <= '0;
      end else if (capture) begin
        code_q <= report_code;
        id_q   <= report_id;
        tval_q <= report_tval;
      end
    end
  end

  // Without M-mode support the whole endpoint is inert.
  assign exception.valid = MModeEn & (state_q == PENDING);
  assign exception.code  = MModeEn ? code_q : INST_ADDR_MISALIGNED;
  assign exception.id    = MModeEn ? id_q : '0;
  assign exception.tval  = MModeEn ? tval_q : '0;
  assign discarding      = MModeEn & (state_q == DISCARD);
  assign report_dropped  = MModeEn & drop;

endmodule

// File: tb/tb_exception_reporter.sv
// Directed table-driven bench for exception_reporter with hand-written sequences
// for the ack/suppress window and reset-in-DISCARD cases.
module tb_exception_reporter;
  import exception_reporter_pkg::*;

  typedef struct {
    logic            rv;
    exception_code_t code;
    id_t             id;
    logic [31:0]     tval;
    id_t             oldest;
    logic            ack;
    logic            sup;
    logic            ic;
    logic            expDrop;
    logic            expValid;
    exception_code_t expCode;
    id_t             expId;
    logic [31:0]     expTval;
    logic            expDisc;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            reportValid;
  exception_code_t reportCode;
  id_t             reportId;
  logic [31:0]     reportTval;
  id_t             oldestId;
  logic            writebackSuppress;
  logic            initClear;
  logic            reportDropped;
  logic            discarding;

  int vectorCount = 0;
  int miscompares = 0;

  exception_interface exc();

  exception_reporter #(.CONFIG(EXAMPLE_CONFIG)) dut (
    .clk                (clk),
    .rst                (rst),
    .report_valid       (reportValid),
    .report_code        (reportCode),
    .report_id          (reportId),
    .report_tval        (reportTval),
    .oldest_id          (oldestId),
    .writeback_suppress (writebackSuppress),
    .init_clear         (initClear),
    .exception          (exc),
    .report_dropped     (reportDropped),
    .discarding         (discarding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic rv, input exception_code_t code, input id_t id, input logic [31:0] tval,
    input id_t oldest, input logic ack, input logic sup, input logic ic,
    input logic expDrop, input logic expValid, input exception_code_t expCode,
    input id_t expId, input logic [31:0] expTval, input logic expDisc);
    vec_t v;
    v.rv = rv; v.code = code; v.id = id; v.tval = tval; v.oldest = oldest;
    v.ack = ack; v.sup = sup; v.ic = ic;
    v.expDrop = expDrop; v.expValid = expValid; v.expCode = expCode;
    v.expId = expId; v.expTval = expTval; v.expDisc = expDisc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic rstVal);
    rst               = rstVal;
    reportValid       = v.rv;
    reportCode        = v.code;
    reportId          = v.id;
    reportTval        = v.tval;
    oldestId          = v.oldest;
    exc.ack           = v.ack;
    writebackSuppress = v.sup;
    initClear         = v.ic;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle: dropped is checked before the edge, registered outputs after it.
  task automatic runStep(input vec_t v, input string tag);
    applyStimulus(v, 1'b0);
    #1;
    checkOutput({tag, ".dropped"}, 32'(reportDropped), 32'(v.expDrop));
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, 32'(exc.valid), 32'(v.expValid));
    checkOutput({tag, ".discarding"}, 32'(discarding), 32'(v.expDisc));
    if (v.expValid) begin
      checkOutput({tag, ".code"}, 32'(exc.code), 32'(v.expCode));
      checkOutput({tag, ".id"}, 32'(exc.id), 32'(v.expId));
      checkOutput({tag, ".tval"}, exc.tval, v.expTval);
    end
    vectorCount++;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".valid"}, 32'(exc.valid), 32'd0);
    checkOutput({tag, ".code"}, 32'(exc.code), 32'd0);
    checkOutput({tag, ".id"}, 32'(exc.id), 32'd0);
    checkOutput({tag, ".tval"}, exc.tval, 32'd0);
    checkOutput({tag, ".dropped"}, 32'(reportDropped), 32'd0);
    checkOutput({tag, ".discarding"}, 32'(discarding), 32'd0);
    vectorCount++;
  endtask

  vec_t vecs[18];
  vec_t idleVec;

  initial begin
    idleVec = mkVec(0, INST_ADDR_MISALIGNED, 0, 0, 0, 0, 0, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 0);

    //                rv code                     id  tval        old ack sup ic  drp vld expCode               eId eTval       disc
    vecs[0]  = mkVec(1, LOAD_FAULT,              5,  32'h1000,   3,  0,  0,  0,  0,  1,  LOAD_FAULT,           5,  32'h1000,   0);
    vecs[1]  = mkVec(0, INST_ADDR_MISALIGNED,    0,  0,          3,  1,  0,  0,  0,  0,  INST_ADDR_MISALIGNED, 0,  0,          1);
    vecs[2]  = mkVec(0, INST_ADDR_MISALIGNED,    0,  0,          3,  0,  1,  0,  0,  0,  INST_ADDR_MISALIGNED, 0,  0,          1);
    vecs[3]  = mkVec(0, INST_ADDR_MISALIGNED,    0,  0,          3,  0,  0,  0,  0,  0,  INST_ADDR_MISALIGNED, 0,  0,          0);
    vecs[4]  = mkVec(1, LOAD_PAGE_FAULT,         7,  32'h2000,   2,  0,  0,  0,  0,  1,  LOAD_PAGE_FAULT,      7,  32'h2000,   0);
    vecs[5]  = mkVec(1, STORE_AMO_FAULT,         4,  32'h3000,   2,  0,  0,  0,  0,  1,  STORE_AMO_FAULT,      4,  32'h3000,   0);
    vecs[6]  = mkVec(1, ILLEGAL_INST,            9,  32'h4000,   2,  0,  0,  0,  1,  1,  STORE_AMO_FAULT,      4,  32'h3000,   0);
    vecs[7]  = mkVec(1, BREAKPOINT,              4,  32'h5555,   2,  0,  0,  0,  1,  1,  STORE_AMO_FAULT,      4,  32'h3000,   0);
    vecs[8]  = mkVec(1, ECALL_M,                 1,  32'h6000,   62, 0,  0,  0,  0,  1,  ECALL_M,              1,  32'h6000,   0);
    vecs[9]  = mkVec(1, LOAD_ADDR_MISALIGNED,    63, 32'h7000,   62, 0,  0,  0,  0,  1,  LOAD_ADDR_MISALIGNED, 63, 32'h7000,   0);
    vecs[10] = mkVec(1, ILLEGAL_INST,            0,  32'h8000,   62, 0,  0,  0,  1,  1,  LOAD_ADDR_MISALIGNED, 63, 32'h7000,   0);
    vecs[11] = mkVec(1, ECALL_U,                 62, 32'h8800,   62, 0,  0,  1,  1,  0,  INST_ADDR_MISALIGNED, 0,  0,          0);
    vecs[12] = mkVec(1, INST_ACCESS_FAULT,       10, 32'h9000,   8,  0,  0,  0,  0,  1,  INST_ACCESS_FAULT,    10, 32'h9000,   0);
    vecs[13] = mkVec(1, STORE_AMO_FAULT,         8,  32'h9100,   8,  1,  0,  0,  1,  0,  INST_ADDR_MISALIGNED, 0,  0,          1);
    vecs[14] = mkVec(1, STORE_AMO_FAULT,         8,  32'h9200,   8,  0,  0,  0,  1,  0,  INST_ADDR_MISALIGNED, 0,  0,          1);
    vecs[15] = mkVec(0, INST_ADDR_MISALIGNED,    0,  0,          8,  0,  0,  1,  0,  0,  INST_ADDR_MISALIGNED, 0,  0,          0);
    vecs[16] = mkVec(0, INST_ADDR_MISALIGNED,    0,  0,          8,  1,  0,  0,  0,  0,  INST_ADDR_MISALIGNED, 0,  0,          0);
    vecs[17] = mkVec(1, ILLEGAL_INST,            3,  32'hA,      3,  1,  0,  0,  0,  1,  ILLEGAL_INST,         3,  32'hA,      0);

    applyStimulus(idleVec, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");

    for (int i = 0; i < 18; i++) begin
      runStep(vecs[i], $sformatf("vec%0d", i));
    end

    // Ack at c10 while reporting, suppress high c12-c14, exit cycle c15, capture at c16.
    runStep(mkVec(1, LOAD_FAULT, 1, 32'hA0, 1, 1, 0, 0, 1, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "win.c10");
    runStep(mkVec(1, LOAD_FAULT, 1, 32'hA1, 1, 0, 0, 0, 1, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "win.c11");
    runStep(mkVec(1, LOAD_FAULT, 1, 32'hA2, 1, 0, 1, 0, 1, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "win.c12");
    runStep(mkVec(0, LOAD_FAULT, 0, 0,      1, 0, 1, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "win.c13");
    runStep(mkVec(0, LOAD_FAULT, 0, 0,      1, 0, 1, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "win.c14");
    runStep(mkVec(1, LOAD_FAULT, 2, 32'hA5, 1, 0, 0, 0, 1, 0, INST_ADDR_MISALIGNED, 0, 0, 0), "win.c15");
    runStep(mkVec(1, LOAD_FAULT, 2, 32'hB0, 1, 0, 0, 0, 0, 1, LOAD_FAULT, 2, 32'hB0, 0), "win.c16");

    // Reset while discarding with suppress still high, then normal capture afterwards.
    runStep(mkVec(0, LOAD_FAULT, 0, 0, 1, 1, 0, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "rst.ack");
    runStep(mkVec(0, LOAD_FAULT, 0, 0, 1, 0, 1, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "rst.sup");
    applyStimulus(mkVec(0, LOAD_FAULT, 0, 0, 1, 0, 1, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 0), 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(idleVec, 1'b0);
    #1;
    checkResetValues("rst.mid");
    runStep(mkVec(1, STORE_AMO_FAULT, 20, 32'hC0, 20, 0, 0, 0, 0, 1, STORE_AMO_FAULT, 20, 32'hC0, 0), "rst.capture");
    runStep(mkVec(0, LOAD_FAULT, 0, 0, 20, 1, 0, 0, 0, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "rst.ack2");
    runStep(mkVec(1, LOAD_FAULT, 21, 32'hC1, 20, 0, 0, 0, 1, 0, INST_ADDR_MISALIGNED, 0, 0, 1), "rst.hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
